// File: rtl/pipe_ctrl_stage.sv
// Generic pipeline-stage control register: EX/MEM/WB control groups plus a
// data payload, valid/ready handshake, optional skid entry, flush-to-bubble
// and saturating bubble/flush statistics.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | main entry invalid; outputs present the all-zero bubble
// ONE   | main entry valid and presented downstream
// TWO   | main and skid entries valid; skid drains next (SKID=1 only)
module pipe_ctrl_stage #(
  parameter int EX_W   = 10,
  parameter int MEM_W  = 12,
  parameter int WB_W   = 7,
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EX_W-1:0]   in_ex,
  input  logic [MEM_W-1:0]  in_mem,
  input  logic [WB_W-1:0]   in_wb,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EX_W-1:0]   out_ex,
  output logic [MEM_W-1:0]  out_mem,
  output logic [WB_W-1:0]   out_wb,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // One entry is the four groups packed MSB-first: {ex, mem, wb, data}.
  localparam int ENT_W = EX_W + MEM_W + WB_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t             state_q, state_d;
  logic [ENT_W-1:0] m_q, m_d;
  logic [ENT_W-1:0] s_q, s_d;
  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] out_ent;
  logic             accept;
  logic             retire;
  logic [CNT_W-1:0] bubble_q;
  logic [CNT_W-1:0] flush_q;

  assign in_ent    = {in_ex, in_mem, in_wb, in_data};
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;

  // With a skid entry, ready depends only on the occupancy register, so the
  // upstream never sees a combinational path from out_ready.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = (state_q != TWO);
    end else begin : g_comb_ready
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

  // Occupancy state and entry storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  // Next occupancy and entry contents; vacated entries are zeroed so the
  // stored word is already the NOP bubble whenever it is not valid.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (clr) begin
      state_d = EMPTY;
      m_d     = '0;
      s_d     = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            m_d     = in_ent;
          end
        end
        ONE: begin
          if (retire && accept) begin
            m_d = in_ent;
          end else if (retire) begin
            state_d = EMPTY;
            m_d     = '0;
          end else if (accept && (SKID != 0)) begin
            state_d = TWO;
            s_d     = in_ent;
          end
        end
        TWO: begin
          if (retire) begin
            state_d = ONE;
            m_d     = s_q;
            s_d     = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          m_d     = '0;
          s_d     = '0;
        end
      endcase
    end
  end

  // Bubble counter: cycles where downstream was ready but got nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
    end else if (!out_valid && out_ready && (bubble_q != CNT_MAX)) begin
      bubble_q <= bubble_q + 1'b1;
    end
  end

  // Flush counter: only flushes that actually discarded something count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q <= '0;
    end else if (clr && (state_q != EMPTY) && (flush_q != CNT_MAX)) begin
      flush_q <= flush_q + 1'b1;
    end
  end

  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;

  // The gate keeps the bubble word all-zero even if storage were stale.
  assign out_ent  = out_valid ? m_q : '0;
  assign out_ex   = out_ent[ENT_W-1 -: EX_W];
  assign out_mem  = out_ent[DATA_W+WB_W+MEM_W-1 -: MEM_W];
  assign out_wb   = out_ent[DATA_W+WB_W-1 -: WB_W];
  assign out_data = out_ent[DATA_W-1:0];

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Directed bench for pipe_ctrl_stage: default skid stage, a SKID=0 stage and
// a CNT_W=4 stage for counter saturation.
module tb_pipe_ctrl_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // default stage (SKID=1, CNT_W=16)
  logic        clr, in_valid, in_ready, out_valid, out_ready;
  logic [9:0]  in_ex, out_ex;
  logic [11:0] in_mem, out_mem;
  logic [6:0]  in_wb, out_wb;
  logic [31:0] in_data, out_data;
  logic [15:0] bubble_cnt, flush_cnt;

  // SKID=0 stage
  logic        ns_in_valid, ns_in_ready, ns_out_valid, ns_out_ready;
  logic [9:0]  ns_out_ex;
  logic [11:0] ns_out_mem;
  logic [6:0]  ns_out_wb;
  logic [31:0] ns_in_data, ns_out_data;
  logic [15:0] ns_bubble, ns_flush;

  // CNT_W=4 stage
  logic        sat_in_ready, sat_out_valid, sat_out_ready;
  logic [9:0]  sat_out_ex;
  logic [11:0] sat_out_mem;
  logic [6:0]  sat_out_wb;
  logic [31:0] sat_out_data;
  logic [3:0]  sat_bubble, sat_flush;

  pipe_ctrl_stage u_dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ex(in_ex), .in_mem(in_mem), .in_wb(in_wb), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ex(out_ex), .out_mem(out_mem), .out_wb(out_wb), .out_data(out_data),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl_stage #(.SKID(0)) u_ns (
    .clk(clk), .rst(rst), .clr(1'b0),
    .in_valid(ns_in_valid), .in_ready(ns_in_ready),
    .in_ex(10'h155), .in_mem(12'hAAA), .in_wb(7'h55), .in_data(ns_in_data),
    .out_valid(ns_out_valid), .out_ready(ns_out_ready),
    .out_ex(ns_out_ex), .out_mem(ns_out_mem), .out_wb(ns_out_wb), .out_data(ns_out_data),
    .bubble_cnt(ns_bubble), .flush_cnt(ns_flush)
  );

  pipe_ctrl_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .clr(1'b0),
    .in_valid(1'b0), .in_ready(sat_in_ready),
    .in_ex(10'h0), .in_mem(12'h0), .in_wb(7'h0), .in_data(32'h0),
    .out_valid(sat_out_valid), .out_ready(sat_out_ready),
    .out_ex(sat_out_ex), .out_mem(sat_out_mem), .out_wb(sat_out_wb), .out_data(sat_out_data),
    .bubble_cnt(sat_bubble), .flush_cnt(sat_flush)
  );

  // one comparison: counts, asserts, reports on failure
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 0; in_valid = 0; out_ready = 0;
    in_ex = '0; in_mem = '0; in_wb = '0; in_data = '0;
    ns_in_valid = 0; ns_out_ready = 0; ns_in_data = '0;
    sat_out_ready = 0;

    // ---- reset state
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_bubble", bubble_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_ns_in_ready", ns_in_ready, 1);
    chk("rst_sat_bubble", sat_bubble, 0);
    rst = 0;

    // ---- streaming: 8 entries, out_ready=1 (first edge is a bubble)
    out_ready = 1; in_valid = 1;
    in_ex = 10'h3FF; in_mem = 12'hFFF; in_wb = 7'h7F;
    for (int i = 0; i < 8; i++) begin
      in_data = i;
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, i);
      chk("stream_ex", out_ex, 10'h3FF);
      chk("stream_mem", out_mem, 12'hFFF);
      chk("stream_ready", in_ready, 1);
    end
    in_valid = 0;
    step();
    out_ready = 0;
    chk("drain_valid", out_valid, 0);
    chk("drain_ex_zero", out_ex, 0);
    chk("drain_mem_zero", out_mem, 0);
    chk("drain_wb_zero", out_wb, 0);
    chk("drain_data_zero", out_data, 0);
    chk("stream_bubble", bubble_cnt, 1);

    // ---- backpressure into skid
    in_valid = 1; in_data = 32'h11; in_ex = 10'h155; in_mem = 12'hABC; in_wb = 7'h5A;
    step();
    chk("bp_a_data", out_data, 32'h11);
    chk("bp_a_ready", in_ready, 1);
    in_data = 32'h22; in_ex = 10'h2AA; in_mem = 12'h543; in_wb = 7'h25;
    step();
    chk("bp_two_data", out_data, 32'h11);
    chk("bp_two_mem", out_mem, 12'hABC);
    chk("bp_two_ready", in_ready, 0);
    in_data = 32'h99;
    step();
    chk("bp_hold_data", out_data, 32'h11);
    chk("bp_hold_ready", in_ready, 0);
    in_valid = 0; out_ready = 1;
    step();
    chk("bp_b_data", out_data, 32'h22);
    chk("bp_b_ex", out_ex, 10'h2AA);
    chk("bp_b_wb", out_wb, 7'h25);
    chk("bp_b_ready", in_ready, 1);
    step();
    out_ready = 0;
    chk("bp_empty_valid", out_valid, 0);
    chk("bp_bubble", bubble_cnt, 1);

    // ---- flush from TWO with a concurrent offer
    in_valid = 1; in_data = 32'h44; in_mem = 12'hFFF;
    step();
    in_data = 32'h55;
    step();
    chk("fl_two_ready", in_ready, 0);
    clr = 1; in_data = 32'h33; out_ready = 1;
    #1;
    chk("fl_preflush_data", out_data, 32'h44);
    step();
    clr = 1; in_valid = 0; out_ready = 0;
    chk("fl_valid", out_valid, 0);
    chk("fl_mem_zero", out_mem, 12'h000);
    chk("fl_data_zero", out_data, 0);
    chk("fl_cnt", flush_cnt, 1);
    chk("fl_ready", in_ready, 1);
    step();
    clr = 0;
    chk("fl_empty_cnt", flush_cnt, 1);
    step();
    chk("fl_c_dropped", out_valid, 0);

    // ---- async reset while holding TWO
    in_valid = 1; in_data = 32'h66;
    step();
    in_data = 32'h77;
    step();
    in_valid = 0;
    chk("rm_two_ready", in_ready, 0);
    rst = 1;
    #1;
    chk("rm_valid", out_valid, 0);
    chk("rm_data", out_data, 0);
    chk("rm_mem", out_mem, 0);
    chk("rm_ready", in_ready, 1);
    chk("rm_flush", flush_cnt, 0);
    chk("rm_bubble", bubble_cnt, 0);
    step();
    rst = 0;
    in_valid = 1; in_data = 32'h88; out_ready = 1;
    step();
    in_valid = 0;
    chk("rm_next_valid", out_valid, 1);
    chk("rm_next_data", out_data, 32'h88);
    step();
    chk("rm_next_drain", out_valid, 0);
    chk("rm_bubble1", bubble_cnt, 1);
    step();
    out_ready = 0;
    chk("rm_bubble2", bubble_cnt, 2);

    // ---- SKID=0: combinational ready
    ns_in_valid = 1; ns_in_data = 32'hA1;
    #1;
    chk("ns_empty_ready", ns_in_ready, 1);
    step();
    ns_in_valid = 0;
    #1;
    chk("ns_one_data", ns_out_data, 32'hA1);
    chk("ns_blocked", ns_in_ready, 0);
    ns_out_ready = 1;
    #1;
    chk("ns_follow_hi", ns_in_ready, 1);
    ns_out_ready = 0;
    #1;
    chk("ns_follow_lo", ns_in_ready, 0);
    ns_out_ready = 1; ns_in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ns_in_data = 32'hB0 + i;
      step();
      chk("ns_tp_data", ns_out_data, 32'hB0 + i);
      chk("ns_tp_ready", ns_in_ready, 1);
    end
    ns_in_valid = 0;
    step();
    ns_out_ready = 0;
    chk("ns_drain", ns_out_valid, 0);
    chk("ns_bits_zero", {ns_out_ex, ns_out_mem, ns_out_wb}, 0);

    // ---- CNT_W=4 saturation
    sat_out_ready = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk("sat_14", sat_bubble, 14);
    end
    chk("sat_15", sat_bubble, 15);
    sat_out_ready = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // hard time bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
